sm83_irq_ctrl: RTL and testbench
================================

# sm83_irq_ctrl

Parametrised interrupt controller for the SM83 core. It replaces the fixed 8-line IRQ trigger/acknowledge pair with a configurable-width block that owns IF, IE, IME and EI delay, and sequences priority dispatch. It sits between the peripheral IRQ sources and the sequencer. It supplies the vector and HALT/STOP wake, and exposes IF/IE to the MMIO decoder.

## Interface
- NUM_IRQ, 5: number of interrupt lines, 1..8; bit 0 is highest priority.
- VEC_BASE, 16'h0040: vector of line 0.
- VEC_STEP, 8: byte spacing between vectors.
- CLK  in  1  single core clock; all state on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IRQ_TRIG  in  NUM_IRQ  peripheral request levels; rising edge sets the IF bit.
- REG_SEL  in  1  0 = IF, 1 = IE.
- REG_WR  in  1  write strobe, one cycle.
- REG_WDATA  in  8  write data.
- REG_RDATA  out  8  read data, combinational from REG_SEL.
- EI, DI, RETI  in  1 each  one-cycle strobes from the instruction decoder.
- INSN_END  in  1  one-cycle strobe at each opcode fetch (LoadIR).
- INT_ACK  in  1  sequencer starts the dispatch M-cycles.
- INT_DONE  in  1  sequencer has consumed VECTOR.
- INT_REQ  out  1  dispatch requested.
- VECTOR  out  16  dispatch target; valid in VEC state.
- IRQ_ACK  out  NUM_IRQ  one-hot, one-cycle pulse for the serviced line.
- IME  out  1  master enable.
- WAKE  out  1  any enabled request is pending.

## Operation
- Edge detect: IRQ_TRIG is registered each cycle. `trig & ~trig_q` sets IF[i].
- IF write: bits [NUM_IRQ-1:0] take REG_WDATA. If a trigger edge hits the same bit in the same cycle, the trigger wins and the bit stays 1.
- IE is a full 8-bit register. Only bits [NUM_IRQ-1:0] take part in requests.
- Read: IF bits ≥ NUM_IRQ read 1. IE reads back all 8 stored bits.
- pend = IF & IE[NUM_IRQ-1:0]. WAKE = |pend, independent of IME.
- IME control:
  - EI sets ime_arm.
  - On the next INSN_END with ime_arm set: IME←1, ime_arm←0. An EI and INSN_END in the same cycle counts as arming only.
  - DI clears IME and ime_arm immediately, and wins over a simultaneous EI or RETI.
  - RETI sets IME immediately.
- State machine, states IDLE, REQ, VEC:
  - IDLE→REQ when IME & |pend. INT_REQ=1 in REQ.
  - REQ→IDLE if IME or |pend drops before INT_ACK. INT_REQ deasserts with no side effects.
  - REQ→VEC on INT_ACK:
    - Winner is the lowest index set in pend at that cycle. VECTOR←VEC_BASE + winner*VEC_STEP.
    - Clear IF[winner] (a simultaneous trigger edge on that bit keeps it set).
    - Pulse IRQ_ACK[winner]. IME←0, ime_arm←0.
  - ACK race: if pend is 0 in the INT_ACK cycle, VECTOR←16'h0000, no IF bit is cleared, IRQ_ACK stays 0, and IME is still cleared.
  - VEC→IDLE on INT_DONE. VECTOR holds its value until the next dispatch.
  - INT_ACK outside REQ is ignored.
- Reset, asynchronous: IF=0, IE=0, IME=0, ime_arm=0, trig_q=0, state=IDLE. Outputs: INT_REQ=0, VECTOR=0, IRQ_ACK=0, WAKE=0. REG_RDATA(IF) = ones above NUM_IRQ, zeros below. Reset mid-dispatch aborts with no ACK pulse.

## Timing
- Trigger edge at cycle n: IF set at n+1, WAKE at n+1, INT_REQ at n+2 (if IME=1).
- INT_ACK sampled at n: at n+1, VECTOR is valid, IRQ_ACK pulses, IF bit is clear and IME=0.
- EI then INSN_END at k: IME=1 at k+1. Earliest INT_REQ is k+2.
- REG_WR at n: register updated at n+1.

## Structure
- Package sm83_irq_pkg holds: state enum (IDLE, REQ, VEC), REG_IF/REG_IE select constants, and the default VEC_BASE and VEC_STEP.
- Sub-module irq_prio_enc(NUM_IRQ): combinational lowest-index priority encoder producing a one-hot output, an index and a valid flag. It is the only sub-module.
- Everything else is flat.

## Test plan
- NUM_IRQ=5, IE=0x1F, IME=1: edge on lines 2 and 4 together, then INT_ACK → VECTOR=0x0050, IRQ_ACK=5'b00100, IF reads 0xF0|0x10=0xF0 with bit 4 still set.
- EI at n, INSN_END at n+3, IF.0 already pending → IME=1 at n+4, INT_REQ at n+5. EI+DI in the same cycle → IME stays 0.
- In REQ, write IF=0 before INT_ACK → INT_REQ drops, returns to IDLE. Write IF=0 in the same cycle as INT_ACK → VECTOR=0x0000, IRQ_ACK=0, IME=0.
- IME=0, IE.3=1, edge on line 3 → WAKE=1 one cycle later, INT_REQ stays 0.
- NUM_IRQ=8, VEC_STEP=8: line 7 alone → VECTOR=0x0078. IF reads 0x80, then 0x00 after dispatch.
- Assert RESET during VEC → all outputs return to reset values immediately. A trigger held high through reset release does not set IF; only a new rising edge does.

Source files
------------

// File: rtl/sm83_irq_pkg.sv
// Shared types and constants for the SM83 interrupt controller.
package sm83_irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        VEC  = 2'd2
    } irq_state_e;

    localparam logic REG_IF = 1'b0;
    localparam logic REG_IE = 1'b1;

    localparam logic [15:0] DEF_VEC_BASE = 16'h0040;
    localparam int          DEF_VEC_STEP = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and valid.
module irq_prio_enc #(
    parameter int NUM_IRQ = 5
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [NUM_IRQ-1:0] onehot,
    output logic [2:0]         index,
    output logic               valid
);

    // Walk from the highest index down so the lowest set bit is the last writer.
    always_comb begin
        onehot = {NUM_IRQ{1'b0}};
        index  = 3'd0;
        valid  = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = {NUM_IRQ{1'b0}};
                onehot[i] = 1'b1;
                index     = 3'(i);
                valid     = 1'b1;
            end else begin
                index = index;
            end
        end
    end

endmodule

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: owns IF/IE/IME, the EI delay and the dispatch handshake.
module sm83_irq_ctrl
    import sm83_irq_pkg::*;
#(
    parameter int          NUM_IRQ  = 5,
    parameter logic [15:0] VEC_BASE = DEF_VEC_BASE,
    parameter int          VEC_STEP = DEF_VEC_STEP
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_IRQ-1:0] IRQ_TRIG,
    input  logic               REG_SEL,
    input  logic               REG_WR,
    input  logic [7:0]         REG_WDATA,
    output logic [7:0]         REG_RDATA,
    input  logic               EI,
    input  logic               DI,
    input  logic               RETI,
    input  logic               INSN_END,
    input  logic               INT_ACK,
    input  logic               INT_DONE,
    output logic               INT_REQ,
    output logic [15:0]        VECTOR,
    output logic [NUM_IRQ-1:0] IRQ_ACK,
    output logic               IME,
    output logic               WAKE
);

    irq_state_e         state_r, state_nxt_s;
    logic [NUM_IRQ-1:0] if_r, if_nxt_s;
    logic [7:0]         ie_r;
    logic [NUM_IRQ-1:0] trig_q_r;
    logic               edge_en_r;
    logic               ime_r, ime_nxt_s;
    logic               ime_arm_r, arm_nxt_s;
    logic               int_req_r;
    logic [15:0]        vector_r;
    logic [NUM_IRQ-1:0] irq_ack_r;

    logic [NUM_IRQ-1:0] edge_s;
    logic [NUM_IRQ-1:0] pend_s;
    logic               any_pend_s;
    logic               dispatch_s;
    logic [NUM_IRQ-1:0] win_onehot_s;
    logic [2:0]         win_index_s;
    logic               win_valid_s;
    logic [15:0]        win_vector_s;

    // Edge detection is masked for the first cycle after reset so that a
    // line already high at reset release is absorbed rather than latched.
    assign edge_s     = IRQ_TRIG & ~trig_q_r & {NUM_IRQ{edge_en_r}};
    assign pend_s     = if_r & ie_r[NUM_IRQ-1:0];
    assign any_pend_s = |pend_s;
    assign dispatch_s = (state_r == REQ) && INT_ACK;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req    (pend_s),
        .onehot (win_onehot_s),
        .index  (win_index_s),
        .valid  (win_valid_s)
    );

    assign win_vector_s = VEC_BASE + (16'(win_index_s) * 16'(VEC_STEP));

    // Unimplemented IF bits read as 1; IE reads back all stored bits.
    always_comb begin
        REG_RDATA = 8'hFF;
        if (REG_SEL == REG_IE) begin
            REG_RDATA = ie_r;
        end else begin
            REG_RDATA[NUM_IRQ-1:0] = if_r;
        end
    end

    // IF update: write, then dispatch clear, with trigger edges overriding both.
    always_comb begin
        if_nxt_s = if_r;
        if (REG_WR && (REG_SEL == REG_IF)) begin
            if_nxt_s = REG_WDATA[NUM_IRQ-1:0];
        end else begin
            if_nxt_s = if_r;
        end
        if (dispatch_s && win_valid_s) begin
            if_nxt_s = if_nxt_s & ~win_onehot_s;
        end else begin
            if_nxt_s = if_nxt_s;
        end
        if_nxt_s = if_nxt_s | edge_s;
    end

    // IME control; later statements take priority: DI over dispatch over RETI/EI.
    always_comb begin
        ime_nxt_s = ime_r;
        arm_nxt_s = ime_arm_r;
        if (EI) begin
            arm_nxt_s = 1'b1;
        end else if (INSN_END && ime_arm_r) begin
            ime_nxt_s = 1'b1;
            arm_nxt_s = 1'b0;
        end else begin
            arm_nxt_s = ime_arm_r;
        end
        if (RETI) begin
            ime_nxt_s = 1'b1;
        end else begin
            ime_nxt_s = ime_nxt_s;
        end
        if (dispatch_s || DI) begin
            ime_nxt_s = 1'b0;
            arm_nxt_s = 1'b0;
        end else begin
            arm_nxt_s = arm_nxt_s;
        end
    end

    // Dispatch sequencer next-state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (ime_r && any_pend_s) state_nxt_s = REQ;
                else                     state_nxt_s = IDLE;
            end
            REQ: begin
                if (INT_ACK)                     state_nxt_s = VEC;
                else if (!(ime_r && any_pend_s)) state_nxt_s = IDLE;
                else                             state_nxt_s = REQ;
            end
            VEC: begin
                if (INT_DONE) state_nxt_s = IDLE;
                else          state_nxt_s = VEC;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, register file and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r   <= IDLE;
            if_r      <= {NUM_IRQ{1'b0}};
            ie_r      <= 8'h00;
            trig_q_r  <= {NUM_IRQ{1'b0}};
            edge_en_r <= 1'b0;
            ime_r     <= 1'b0;
            ime_arm_r <= 1'b0;
            int_req_r <= 1'b0;
            vector_r  <= 16'h0000;
            irq_ack_r <= {NUM_IRQ{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            if_r      <= if_nxt_s;
            trig_q_r  <= IRQ_TRIG;
            edge_en_r <= 1'b1;
            ime_r     <= ime_nxt_s;
            ime_arm_r <= arm_nxt_s;
            int_req_r <= (state_nxt_s == REQ);
            if (REG_WR && (REG_SEL == REG_IE)) ie_r <= REG_WDATA;
            else                               ie_r <= ie_r;
            if (dispatch_s) begin
                vector_r  <= win_valid_s ? win_vector_s : 16'h0000;
                irq_ack_r <= win_valid_s ? win_onehot_s : {NUM_IRQ{1'b0}};
            end else begin
                vector_r  <= vector_r;
                irq_ack_r <= {NUM_IRQ{1'b0}};
            end
        end
    end

    assign INT_REQ = int_req_r;
    assign VECTOR  = vector_r;
    assign IRQ_ACK = irq_ack_r;
    assign IME     = ime_r;
    assign WAKE    = any_pend_s;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Directed bench for sm83_irq_ctrl: a 5-line and an 8-line instance share controls.
module tb_sm83_irq_ctrl;

    logic        CLK;
    logic        RESET;
    logic [4:0]  trig5;
    logic [7:0]  trig8;
    logic        REG_SEL, REG_WR;
    logic [7:0]  REG_WDATA;
    logic        EI, DI, RETI, INSN_END, INT_ACK, INT_DONE;

    logic [7:0]  rd5, rd8;
    logic        req5, req8, ime5, ime8, wake5, wake8;
    logic [15:0] vec5, vec8;
    logic [4:0]  ack5;
    logic [7:0]  ack8;

    int checks = 0;
    int errors = 0;

    sm83_irq_ctrl #(.NUM_IRQ(5)) dut5 (
        .CLK(CLK), .RESET(RESET), .IRQ_TRIG(trig5),
        .REG_SEL(REG_SEL), .REG_WR(REG_WR), .REG_WDATA(REG_WDATA), .REG_RDATA(rd5),
        .EI(EI), .DI(DI), .RETI(RETI), .INSN_END(INSN_END),
        .INT_ACK(INT_ACK), .INT_DONE(INT_DONE),
        .INT_REQ(req5), .VECTOR(vec5), .IRQ_ACK(ack5), .IME(ime5), .WAKE(wake5)
    );

    sm83_irq_ctrl #(.NUM_IRQ(8), .VEC_BASE(16'h0040), .VEC_STEP(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .IRQ_TRIG(trig8),
        .REG_SEL(REG_SEL), .REG_WR(REG_WR), .REG_WDATA(REG_WDATA), .REG_RDATA(rd8),
        .EI(EI), .DI(DI), .RETI(RETI), .INSN_END(INSN_END),
        .INT_ACK(INT_ACK), .INT_DONE(INT_DONE),
        .INT_REQ(req8), .VECTOR(vec8), .IRQ_ACK(ack8), .IME(ime8), .WAKE(wake8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task tick;
        @(posedge CLK);
        #1;
    endtask

    task do_reset;
        trig5 = 5'd0; trig8 = 8'd0;
        REG_SEL = 1'b0; REG_WR = 1'b0; REG_WDATA = 8'h00;
        EI = 1'b0; DI = 1'b0; RETI = 1'b0; INSN_END = 1'b0;
        INT_ACK = 1'b0; INT_DONE = 1'b0;
        RESET = 1'b1;
        tick; tick;
        RESET = 1'b0;
        tick;
    endtask

    task write_reg(input logic sel, input logic [7:0] d);
        REG_SEL = sel; REG_WDATA = d; REG_WR = 1'b1;
        tick;
        REG_WR = 1'b0;
    endtask

    task enable_ime;
        EI = 1'b1; tick; EI = 1'b0;
        INSN_END = 1'b1; tick; INSN_END = 1'b0;
    endtask

    task test_reset;
        do_reset;
        REG_SEL = 1'b0; #1;
        checks++; if (rd5 !== 8'hE0) begin errors++; $display("FAIL reset_if5 got %h exp %h", rd5, 8'hE0); end
        checks++; if (rd8 !== 8'h00) begin errors++; $display("FAIL reset_if8 got %h exp %h", rd8, 8'h00); end
        checks++; if ({req5, ime5, wake5} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {req5, ime5, wake5}); end
        checks++; if (vec5 !== 16'h0000 || ack5 !== 5'd0) begin errors++; $display("FAIL reset_vec got %h/%b exp 0000/00000", vec5, ack5); end
    endtask

    task test_priority;
        write_reg(1'b1, 8'h1F);
        enable_ime;
        checks++; if (ime5 !== 1'b1) begin errors++; $display("FAIL prio_ime got %b exp 1", ime5); end
        trig5 = 5'b10100;
        tick;
        REG_SEL = 1'b0; #1;
        checks++; if (rd5 !== 8'hF4) begin errors++; $display("FAIL prio_if_set got %h exp %h", rd5, 8'hF4); end
        checks++; if (wake5 !== 1'b1 || req5 !== 1'b0) begin errors++; $display("FAIL prio_wake_req got %b%b exp 10", wake5, req5); end
        tick;
        checks++; if (req5 !== 1'b1) begin errors++; $display("FAIL prio_req got %b exp 1", req5); end
        INT_ACK = 1'b1; tick; INT_ACK = 1'b0; trig5 = 5'd0;
        checks++; if (vec5 !== 16'h0050) begin errors++; $display("FAIL prio_vector got %h exp %h", vec5, 16'h0050); end
        checks++; if (ack5 !== 5'b00100) begin errors++; $display("FAIL prio_ack got %b exp 00100", ack5); end
        checks++; if (rd5 !== 8'hF0 || ime5 !== 1'b0) begin errors++; $display("FAIL prio_if_ime got %h/%b exp f0/0", rd5, ime5); end
        tick;
        checks++; if (ack5 !== 5'd0 || vec5 !== 16'h0050) begin errors++; $display("FAIL prio_hold got %b/%h exp 00000/0050", ack5, vec5); end
        INT_DONE = 1'b1; tick; INT_DONE = 1'b0;
    endtask

    task test_ack_race;
        RETI = 1'b1; tick; RETI = 1'b0;
        checks++; if (ime5 !== 1'b1) begin errors++; $display("FAIL race_reti got %b exp 1", ime5); end
        tick;
        checks++; if (req5 !== 1'b1) begin errors++; $display("FAIL race_req got %b exp 1", req5); end
        write_reg(1'b0, 8'h00);
        INT_ACK = 1'b1; tick; INT_ACK = 1'b0;
        checks++; if (vec5 !== 16'h0000 || ack5 !== 5'd0) begin errors++; $display("FAIL race_vec got %h/%b exp 0000/00000", vec5, ack5); end
        checks++; if (ime5 !== 1'b0) begin errors++; $display("FAIL race_ime got %b exp 0", ime5); end
        INT_DONE = 1'b1; tick; INT_DONE = 1'b0;
    endtask

    task test_req_cancel;
        RETI = 1'b1; tick; RETI = 1'b0;
        trig5 = 5'b00001; tick; trig5 = 5'd0;
        tick;
        checks++; if (req5 !== 1'b1) begin errors++; $display("FAIL cancel_req got %b exp 1", req5); end
        write_reg(1'b0, 8'h00);
        tick;
        checks++; if (req5 !== 1'b0 || ime5 !== 1'b1 || ack5 !== 5'd0) begin errors++; $display("FAIL cancel_idle got %b%b%b exp 010", req5, ime5, |ack5); end
    endtask

    task test_ei_delay;
        do_reset;
        write_reg(1'b1, 8'h1F);
        trig5 = 5'b00001; tick; trig5 = 5'd0;
        EI = 1'b1; tick; EI = 1'b0;
        tick; tick;
        checks++; if (ime5 !== 1'b0) begin errors++; $display("FAIL ei_armed got %b exp 0", ime5); end
        INSN_END = 1'b1; tick; INSN_END = 1'b0;
        checks++; if (ime5 !== 1'b1 || req5 !== 1'b0) begin errors++; $display("FAIL ei_ime got %b%b exp 10", ime5, req5); end
        tick;
        checks++; if (req5 !== 1'b1) begin errors++; $display("FAIL ei_req got %b exp 1", req5); end
        DI = 1'b1; tick; DI = 1'b0;
        checks++; if (ime5 !== 1'b0) begin errors++; $display("FAIL di_clear got %b exp 0", ime5); end
        tick;
        EI = 1'b1; DI = 1'b1; tick; EI = 1'b0; DI = 1'b0;
        INSN_END = 1'b1; tick; INSN_END = 1'b0;
        tick;
        checks++; if (ime5 !== 1'b0 || req5 !== 1'b0) begin errors++; $display("FAIL ei_di got %b%b exp 00", ime5, req5); end
        EI = 1'b1; INSN_END = 1'b1; tick; EI = 1'b0;
        checks++; if (ime5 !== 1'b0) begin errors++; $display("FAIL ei_same_cycle got %b exp 0", ime5); end
        tick; INSN_END = 1'b0;
        checks++; if (ime5 !== 1'b1) begin errors++; $display("FAIL ei_next_end got %b exp 1", ime5); end
    endtask

    task test_wake;
        do_reset;
        write_reg(1'b1, 8'h08);
        trig5 = 5'b01000; tick;
        checks++; if (wake5 !== 1'b1) begin errors++; $display("FAIL wake_set got %b exp 1", wake5); end
        tick; trig5 = 5'd0;
        REG_SEL = 1'b1; #1;
        checks++; if (req5 !== 1'b0 || rd5 !== 8'h08) begin errors++; $display("FAIL wake_noreq got %b/%h exp 0/08", req5, rd5); end
    endtask

    task test_line7;
        do_reset;
        write_reg(1'b1, 8'hFF);
        enable_ime;
        trig8 = 8'h80; tick;
        REG_SEL = 1'b0; #1;
        checks++; if (rd8 !== 8'h80) begin errors++; $display("FAIL l7_if got %h exp 80", rd8); end
        tick;
        checks++; if (req8 !== 1'b1 || req5 !== 1'b0) begin errors++; $display("FAIL l7_req got %b%b exp 10", req8, req5); end
        INT_ACK = 1'b1; tick; INT_ACK = 1'b0;
        checks++; if (vec8 !== 16'h0078) begin errors++; $display("FAIL l7_vector got %h exp 0078", vec8); end
        checks++; if (ack8 !== 8'h80 || rd8 !== 8'h00) begin errors++; $display("FAIL l7_ack_if got %h/%h exp 80/00", ack8, rd8); end
        checks++; if (ack5 !== 5'd0 || ime5 !== 1'b1) begin errors++; $display("FAIL ack_outside_req got %b/%b exp 00000/1", ack5, ime5); end
    endtask

    task test_reset_mid;
        trig8 = 8'h01;
        RESET = 1'b1; #1;
        checks++; if (vec8 !== 16'h0000 || ack8 !== 8'h00) begin errors++; $display("FAIL rst_vec_ack got %h/%h exp 0000/00", vec8, ack8); end
        checks++; if ({req8, ime8, wake8} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {req8, ime8, wake8}); end
        tick; tick;
        RESET = 1'b0;
        tick; tick;
        REG_SEL = 1'b0; #1;
        checks++; if (rd8 !== 8'h00) begin errors++; $display("FAIL rst_held_trig got %h exp 00", rd8); end
        trig8 = 8'h00; tick;
        trig8 = 8'h01; tick;
        checks++; if (rd8 !== 8'h01) begin errors++; $display("FAIL rst_new_edge got %h exp 01", rd8); end
        trig8 = 8'h00;
    endtask

    initial begin
        test_reset;
        test_priority;
        test_ack_race;
        test_req_cancel;
        test_ei_delay;
        test_wake;
        test_line7;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
